// File: rtl/sram_frame_writer.sv
// sram_frame_writer
// Streams one frame of 8-bit palette indices into a 16-bit asynchronous SRAM.
// Each accepted pixel becomes one word at linear address y*FRAME_W+x, written
// with a SETUP / WRITE / HOLD sequence so address and data are always stable
// around the WE_N low window. While no load is running the SRAM bus belongs
// to the display read path: the address follows rd_addr and OE_N stays low.

module sram_frame_writer #(
   parameter int FRAME_W   = 640,
   parameter int FRAME_H   = 480,
   parameter int WE_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [7:0]  pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [19:0] rd_addr,
   output logic        busy,
   output logic        done,
   output logic [19:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   localparam int          WCW       = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
   localparam logic [19:0] LAST_ADDR = 20'(FRAME_W * FRAME_H - 1);
   localparam logic [WCW-1:0] WE_LAST = WCW'(WE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_SETUP,
      ST_WRITE,
      ST_HOLD,
      ST_DONE
   } stateT;

   stateT          r_state;
   logic [19:0]    r_wrCnt;
   logic [7:0]     r_data;
   logic [WCW-1:0] r_weCnt;
   logic           r_weN;
   logic           r_oeN;
   logic           r_ready;
   logic           r_busy;
   logic           r_done;
   logic           r_dqEn;

   logic           w_lastPixel;
   logic           w_weLast;
   logic           w_accept;

   assign w_lastPixel = (r_wrCnt == LAST_ADDR);
   assign w_weLast    = (r_weCnt == WE_LAST);
   assign w_accept    = pix_valid && r_ready;

   // The write address only owns the bus while a load is running; otherwise
   // the display read address passes straight through without a register so
   // the read path sees no extra latency.
   assign SRAM_ADDR = r_busy ? r_wrCnt : rd_addr;

   // Data is only put on the shared DQ lines from SETUP through HOLD, and in
   // those states OE_N is already high, so the SRAM and the writer never
   // drive the bus at the same time.
   assign SRAM_DQ = r_dqEn ? {8'h00, r_data} : 16'hzzzz;

   assign pix_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign SRAM_WE_N = r_weN;
   assign SRAM_OE_N = r_oeN;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

   // Main controller. Every bus control output is a register updated on the
   // same edge as the state, so each state's output values are set on the
   // transition into it. Reset may land mid-write; it simply releases WE_N and
   // DQ and returns the bus to the read path, abandoning the current word.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_wrCnt <= '0;
         r_data  <= '0;
         r_weCnt <= '0;
         r_weN   <= 1'b1;
         r_oeN   <= 1'b0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dqEn  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state <= ST_ACCEPT;
                  r_wrCnt <= '0;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b1;
                  r_oeN   <= 1'b1;
               end
            end

            ST_ACCEPT: begin
               if (w_accept) begin
                  r_state <= ST_SETUP;
                  r_data  <= pix_data;
                  r_ready <= 1'b0;
                  r_dqEn  <= 1'b1;
               end
            end

            ST_SETUP: begin
               r_state <= ST_WRITE;
               r_weN   <= 1'b0;
               r_weCnt <= '0;
            end

            ST_WRITE: begin
               if (w_weLast) begin
                  r_state <= ST_HOLD;
                  r_weN   <= 1'b1;
               end else begin
                  r_weCnt <= r_weCnt + WCW'(1);
               end
            end

            ST_HOLD: begin
               r_dqEn <= 1'b0;
               if (w_lastPixel) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_oeN   <= 1'b0;
               end else begin
                  r_state <= ST_ACCEPT;
                  r_wrCnt <= r_wrCnt + 20'd1;
                  r_ready <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_weN   <= 1'b1;
               r_oeN   <= 1'b0;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               r_dqEn  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_frame_writer.sv
// tb_sram_frame_writer
// Small 4x2 frame so whole loads fit in a few hundred cycles. A simple SRAM
// model answers reads whenever OE_N is low; a negedge monitor times every
// WE_N pulse and pops the expected {address, data} pushed at each handshake.

module tb_sram_frame_writer;

   localparam int FW  = 4;
   localparam int FH  = 2;
   localparam int WEC = 2;

   typedef struct {
      logic [7:0]  pix;
      int          gap;
      logic [19:0] expAddr;
      logic [15:0] expData;
   } vecT;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  pixData;
   logic        pixValid;
   logic        pixReady;
   logic [19:0] rdAddr;
   logic        busy;
   logic        done;
   logic [19:0] sramAddr;
   wire  [15:0] sramDq;
   logic        sramWeN;
   logic        sramOeN;
   logic        sramCeN;
   logic        sramUbN;
   logic        sramLbN;

   logic [15:0] mem [16];
   logic [15:0] modelData;
   vecT         vecs [16];

   logic [19:0] sbAddr [$];
   logic [15:0] sbData [$];

   int          total = 0;
   int          bad = 0;
   bit          monOn = 0;
   int          weLowCnt = 0;
   int          writesSeen = 0;
   logic [19:0] pulseAddr = '0;
   logic [15:0] pulseData = '0;

   sram_frame_writer #(
      .FRAME_W   (FW),
      .FRAME_H   (FH),
      .WE_CYCLES (WEC)
   ) dut (
      .Clk       (clk),
      .Reset     (reset),
      .start     (start),
      .pix_data  (pixData),
      .pix_valid (pixValid),
      .pix_ready (pixReady),
      .rd_addr   (rdAddr),
      .busy      (busy),
      .done      (done),
      .SRAM_ADDR (sramAddr),
      .SRAM_DQ   (sramDq),
      .SRAM_WE_N (sramWeN),
      .SRAM_OE_N (sramOeN),
      .SRAM_CE_N (sramCeN),
      .SRAM_UB_N (sramUbN),
      .SRAM_LB_N (sramLbN)
   );

   // SRAM read side: drives DQ only when OE_N is low and no write is active.
   assign modelData = (sramAddr < 20'd16) ? mem[sramAddr[3:0]] : 16'hA500;
   assign sramDq    = (!sramOeN && sramWeN) ? modelData : 16'hzzzz;

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case some wait is never satisfied.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bus monitor: contention check while OE_N is low, WE pulse width and
   // stability, and scoreboard comparison at the end of each pulse.
   always @(negedge clk) begin
      if (monOn) begin
         if (!sramOeN) checkOutput("bus_no_drive_oe_low", sramDq, modelData);
         if (!sramWeN) checkOutput("oe_high_during_we", sramOeN, 1);
         if (reset) begin
            weLowCnt = 0;
            sbAddr.delete();
            sbData.delete();
         end else if (!sramWeN) begin
            if (weLowCnt == 0) begin
               pulseAddr = sramAddr;
               pulseData = sramDq;
            end else begin
               checkOutput("we_addr_stable", sramAddr, pulseAddr);
               checkOutput("we_data_stable", sramDq, pulseData);
            end
            weLowCnt++;
         end else if (weLowCnt != 0) begin
            checkOutput("we_low_cycles", weLowCnt, WEC);
            checkOutput("write_expected", sbAddr.size() != 0, 1);
            if (sbAddr.size() != 0) begin
               checkOutput("write_addr", pulseAddr, sbAddr.pop_front());
               checkOutput("write_data", pulseData, sbData.pop_front());
            end
            if (pulseAddr < 20'd16) mem[pulseAddr[3:0]] = pulseData;
            writesSeen++;
            weLowCnt = 0;
         end
      end
   end

   // Offer one table pixel after its gap and wait (bounded) for the handshake.
   task automatic applyStimulus(input int idx);
      bit hs;
      int waited;
      pixValid = 1'b0;
      repeat (vecs[idx].gap) begin
         @(posedge clk);
         #1;
      end
      pixData  = vecs[idx].pix;
      pixValid = 1'b1;
      hs       = 1'b0;
      waited   = 0;
      while (!hs && waited < 60) begin
         @(negedge clk);
         hs = pixReady;
         @(posedge clk);
         #1;
         waited++;
      end
      pixValid = 1'b0;
      checkOutput("handshake", hs, 1);
      if (hs) begin
         sbAddr.push_back(vecs[idx].expAddr);
         sbData.push_back(vecs[idx].expData);
      end
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Stream table entries first..last; optionally pulse start while the
   // writer waits in ACCEPT for entry startAt, which must be ignored.
   task automatic runFrame(input int first, input int last, input int startAt);
      int guard;
      for (int i = first; i <= last; i++) begin
         if (i == startAt) begin
            guard = 0;
            @(negedge clk);
            while (!pixReady && guard < 20) begin
               @(negedge clk);
               guard++;
            end
            #1;
            pulseStart();
            @(negedge clk);
            checkOutput("midstart_addr", sramAddr, vecs[i].expAddr);
            checkOutput("midstart_busy", busy, 1);
            checkOutput("midstart_ready", pixReady, 1);
         end
         applyStimulus(i);
      end
   endtask

   task automatic checkFrameEnd(input int writesBefore);
      int guard;
      guard = 0;
      while (!done && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("done_reached", done, 1);
      checkOutput("done_busy", busy, 0);
      checkOutput("done_ready", pixReady, 0);
      checkOutput("done_oe_n", sramOeN, 0);
      checkOutput("done_we_n", sramWeN, 1);
      checkOutput("done_addr_is_rd", sramAddr, 20'hABCDE);
      checkOutput("frame_writes", writesSeen - writesBefore, 8);
      checkOutput("sb_leftover", sbAddr.size(), 0);
   endtask

   initial begin
      int lowCnt;
      int guard;
      int wb;

      for (int i = 0; i < 16; i++) mem[i] = 16'hA500;
      for (int i = 0; i < 8; i++) begin
         vecs[i].pix     = 8'(i);
         vecs[i].gap     = int'($urandom_range(0, 3));
         vecs[i].expAddr = 20'(i);
         vecs[i].expData = 16'(i);
      end
      for (int i = 8; i < 16; i++) begin
         vecs[i].pix     = 8'(192 + i);
         vecs[i].gap     = int'($urandom_range(0, 2));
         vecs[i].expAddr = 20'(i - 8);
         vecs[i].expData = 16'(192 + i);
      end

      reset    = 1'b1;
      start    = 1'b0;
      pixValid = 1'b0;
      pixData  = 8'h00;
      rdAddr   = 20'h12345;

      // Reset state with the bus handed to the read path.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_ready", pixReady, 0);
      checkOutput("rst_we_n", sramWeN, 1);
      checkOutput("rst_oe_n", sramOeN, 0);
      checkOutput("rst_ce_ub_lb", {sramCeN, sramUbN, sramLbN}, 3'b000);
      checkOutput("rst_addr", sramAddr, 20'h12345);
      checkOutput("rst_dq_released", sramDq, 16'hA500);
      rdAddr = 20'hABCDE;
      #1;
      checkOutput("rst_addr_follow", sramAddr, 20'hABCDE);
      monOn = 1'b1;
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      // Frame 1: start together with valid, pixel 0x13 first.
      wb       = writesSeen;
      start    = 1'b1;
      pixValid = 1'b1;
      pixData  = 8'h13;
      @(negedge clk);
      checkOutput("idle_ready_with_valid", pixReady, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("accept_ready", pixReady, 1);
      checkOutput("accept_busy", busy, 1);
      checkOutput("accept_oe_n", sramOeN, 1);
      checkOutput("accept_addr", sramAddr, 20'h00000);
      sbAddr.push_back(20'h00000);
      sbData.push_back(16'h0013);
      @(posedge clk);
      #1;
      pixValid = 1'b0;
      @(negedge clk);
      checkOutput("setup_addr", sramAddr, 20'h00000);
      checkOutput("setup_dq", sramDq, 16'h0013);
      checkOutput("setup_we_n", sramWeN, 1);
      lowCnt = 0;
      guard  = 0;
      while (!pixReady && guard < 20) begin
         lowCnt++;
         guard++;
         @(negedge clk);
      end
      checkOutput("ready_gap", lowCnt, 4);
      runFrame(9, 15, -1);
      checkFrameEnd(wb);

      // Frame 2: restart from DONE, stream 0..7, stray start at addr 3.
      @(posedge clk);
      #1;
      wb = writesSeen;
      pulseStart();
      @(negedge clk);
      checkOutput("restart_done_drop", done, 0);
      checkOutput("restart_busy", busy, 1);
      checkOutput("restart_addr", sramAddr, 20'h00000);
      runFrame(0, 7, 3);
      checkFrameEnd(wb);

      // Frame 3: reset while WE_N is low for address 2.
      @(posedge clk);
      #1;
      pulseStart();
      runFrame(0, 1, -1);
      applyStimulus(2);
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_reset_we_n", sramWeN, 0);
      checkOutput("pre_reset_addr", sramAddr, 20'h00002);
      #1 reset = 1'b1;
      @(negedge clk);
      checkOutput("midrst_we_n", sramWeN, 1);
      checkOutput("midrst_oe_n", sramOeN, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_ready", pixReady, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_addr", sramAddr, 20'hABCDE);
      #1 reset = 1'b0;

      // Frame 4: fresh load after reset rewrites from address 0.
      @(posedge clk);
      #1;
      wb = writesSeen;
      pulseStart();
      @(negedge clk);
      checkOutput("reload_addr", sramAddr, 20'h00000);
      runFrame(8, 15, -1);
      checkFrameEnd(wb);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
